// File: rtl/pipe_stage_reg.sv
// Elastic 2-entry pipeline stage register (main + skid) carrying a PC/instruction pair.
// Define PIPE_STAGE_STATS_EN to add stall_cnt/flush_cnt performance counters.
module pipe_stage_reg #(
    parameter int          INSTR_W   = 32,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'hE000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               freeze,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

    logic               main_vld_q, main_vld_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic               skid_vld_q, skid_vld_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic in_fire, out_fire;

    // Skid term is registered; only freeze/flush reach in_ready combinationally.
    assign in_ready  = ~skid_vld_q & ~freeze & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_vld_q & out_ready & ~freeze;

    assign out_valid = main_vld_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_vld_q ? main_instr_q : NOP_W;

    always_comb begin
        main_vld_d   = main_vld_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_vld_d   = skid_vld_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            // Payload registers are left alone so out_pc keeps its last value.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!freeze) begin
            if (!main_vld_q || out_fire) begin
                if (skid_vld_q) begin
                    main_vld_d   = 1'b1;
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                    skid_vld_d   = in_fire;
                    if (in_fire) begin
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end
                end else if (in_fire) begin
                    main_vld_d   = 1'b1;
                    main_pc_d    = in_pc;
                    main_instr_d = in_instr;
                end else begin
                    main_vld_d = 1'b0;
                end
            end else if (in_fire) begin
                skid_vld_d   = 1'b1;
                skid_pc_d    = in_pc;
                skid_instr_d = in_instr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld_q   <= 1'b0;
            main_pc_q    <= '0;
            main_instr_q <= NOP_W;
            skid_vld_q   <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_W;
        end else begin
            main_vld_q   <= main_vld_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_vld_q   <= skid_vld_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((freeze | (main_vld_q & ~out_ready)) & ~flush)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush)
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table plus random traffic against a queue model.
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'hE000_0000;

    logic        clk = 1'b0;
    logic        rst, flush, freeze, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .freeze    (freeze),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of at most two beats.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;
    beat_t       mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_stall, m_flush;

    task automatic model_reset();
        mq.delete();
        m_pc    = 32'h0;
        m_stall = 32'h0;
        m_flush = 32'h0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_out_valid"}, {31'b0, out_valid}, {31'b0, mq.size() > 0});
        check({tag, "_out_pc"}, out_pc, m_pc);
        check({tag, "_out_instr"}, out_instr, (mq.size() > 0) ? mq[0].instr : NOP);
`ifdef PIPE_STAGE_STATS_EN
        check({tag, "_stall_cnt"}, stall_cnt, m_stall);
        check({tag, "_flush_cnt"}, flush_cnt, m_flush);
`endif
    endtask

    // Inputs must already be driven; checks in_ready before the edge, outputs after.
    task automatic tick(input string tag);
        logic rdy, ofire, stall;
        beat_t b;
        #1;
        rdy   = (mq.size() < 2) && !freeze && !flush;
        ofire = (mq.size() > 0) && out_ready && !freeze;
        stall = (freeze || ((mq.size() > 0) && !out_ready)) && !flush;
        check({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
        b.pc = in_pc;
        b.instr = in_instr;
        @(posedge clk);
        #1;
        if (flush) mq.delete();
        else if (!freeze) begin
            if (ofire) void'(mq.pop_front());
            if (rdy && in_valid) mq.push_back(b);
        end
        if (mq.size() > 0) m_pc = mq[0].pc;
        if (stall) m_stall = m_stall + 1;
        if (flush) m_flush = m_flush + 1;
        check_outputs(tag);
    endtask

    typedef struct {
        logic        fl, fr, iv;
        logic [31:0] pc, ins;
        logic        ordy;
        logic        ir, ov;
        logic [31:0] opc, oins;
    } vec_t;
    vec_t vt[24];

    initial begin
        rst = 1'b1; flush = 0; freeze = 0; in_valid = 0; out_ready = 0;
        in_pc = 0; in_instr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, NOP);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        //          fl fr iv pc        instr          ordy ir ov out_pc    out_instr
        vt[0]  = '{0, 0, 1, 32'h100, 32'h1234_5678, 1,  1, 1, 32'h100, 32'h1234_5678};
        vt[1]  = '{0, 0, 0, 32'h0,   32'h0,         1,  1, 0, 32'h100, NOP};
        vt[2]  = '{0, 0, 1, 32'h0,   32'hC0,        1,  1, 1, 32'h0,   32'hC0};
        vt[3]  = '{0, 0, 1, 32'h4,   32'hC4,        1,  1, 1, 32'h4,   32'hC4};
        vt[4]  = '{0, 0, 1, 32'h8,   32'hC8,        1,  1, 1, 32'h8,   32'hC8};
        vt[5]  = '{0, 0, 0, 32'h0,   32'h0,         1,  1, 0, 32'h8,   NOP};
        vt[6]  = '{0, 0, 1, 32'h0,   32'hD0,        0,  1, 1, 32'h0,   32'hD0};
        vt[7]  = '{0, 0, 1, 32'h4,   32'hD4,        0,  1, 1, 32'h0,   32'hD0};
        vt[8]  = '{0, 0, 1, 32'h8,   32'hD8,        0,  0, 1, 32'h0,   32'hD0};
        vt[9]  = '{0, 0, 1, 32'h8,   32'hD8,        1,  0, 1, 32'h4,   32'hD4};
        vt[10] = '{0, 0, 1, 32'h8,   32'hD8,        1,  1, 1, 32'h8,   32'hD8};
        vt[11] = '{0, 0, 0, 32'h0,   32'h0,         1,  1, 0, 32'h8,   NOP};
        vt[12] = '{0, 0, 1, 32'h10,  32'hE10,       0,  1, 1, 32'h10,  32'hE10};
        vt[13] = '{0, 0, 1, 32'h14,  32'hE14,       0,  1, 1, 32'h10,  32'hE10};
        vt[14] = '{1, 0, 1, 32'h18,  32'hE18,       0,  0, 0, 32'h10,  NOP};
        vt[15] = '{0, 0, 0, 32'h0,   32'h0,         1,  1, 0, 32'h10,  NOP};
        vt[16] = '{0, 0, 1, 32'h20,  32'hF20,       1,  1, 1, 32'h20,  32'hF20};
        vt[17] = '{0, 1, 0, 32'h0,   32'h0,         1,  0, 1, 32'h20,  32'hF20};
        vt[18] = '{0, 1, 0, 32'h0,   32'h0,         1,  0, 1, 32'h20,  32'hF20};
        vt[19] = '{0, 1, 0, 32'h0,   32'h0,         1,  0, 1, 32'h20,  32'hF20};
        vt[20] = '{0, 0, 0, 32'h0,   32'h0,         1,  1, 0, 32'h20,  NOP};
        vt[21] = '{0, 0, 1, 32'h30,  32'h30,        0,  1, 1, 32'h30,  32'h30};
        vt[22] = '{1, 1, 0, 32'h0,   32'h0,         0,  0, 0, 32'h30,  NOP};
        vt[23] = '{0, 0, 0, 32'h0,   32'h0,         0,  1, 0, 32'h30,  NOP};

        for (int i = 0; i < 24; i++) begin
            flush = vt[i].fl; freeze = vt[i].fr; in_valid = vt[i].iv;
            in_pc = vt[i].pc; in_instr = vt[i].ins; out_ready = vt[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vt[i].ir});
            tick($sformatf("vec%0d_model", i));
            check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].ov});
            check($sformatf("vec%0d_out_pc", i), out_pc, vt[i].opc);
            check($sformatf("vec%0d_out_instr", i), out_instr, vt[i].oins);
        end

        // Random traffic; PCs step by 4 so ordering errors show up as PC mismatches.
        begin
            logic [31:0] next_pc;
            next_pc = 32'h1000;
            for (int i = 0; i < 400; i++) begin
                flush     = ($urandom_range(15) == 0);
                freeze    = ($urandom_range(5) == 0);
                in_valid  = ($urandom_range(9) < 7);
                out_ready = ($urandom_range(9) < 6);
                in_pc     = next_pc;
                in_instr  = $urandom;
                #1;
                if (in_valid && in_ready) next_pc = next_pc + 4;
                tick($sformatf("rnd%0d", i));
            end
        end

        // Reset while two beats are held: outputs return to reset values immediately.
        flush = 0; freeze = 0; out_ready = 0; in_valid = 1;
        in_pc = 32'h200; in_instr = 32'hAA;
        tick("mid_fill0");
        in_pc = 32'h204; in_instr = 32'hBB;
        tick("mid_fill1");
        in_valid = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_pc", out_pc, 32'h0);
        check("mid_rst_out_instr", out_instr, NOP);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1;
        tick("post_rst_idle");
        in_valid = 1; in_pc = 32'h300; in_instr = 32'h77;
        tick("post_rst_beat");
        check("post_rst_pc", out_pc, 32'h300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic successor to the fixed IF/ID latch. It is a 2-entry pipeline stage register (main + skid) carrying a PC/instruction pair, with a valid/ready handshake, hazard-unit freeze, and branch flush. Any stage boundary (IF/ID, ID/EX, ...) instantiates it. A non-valid output always presents the NOP encoding, so decode never sees stale instructions.

Parameters:
INSTR_W, 32, instruction payload width
PC_W, 32, PC payload width
NOP_INSTR, 32'hE000_0000, encoding driven on out_instr whenever out_valid=0 (truncated/zero-extended to INSTR_W)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
flush  in  1  kill all held and incoming beats
freeze  in  1  hazard stall; holds the stage
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_pc  in  PC_W  upstream PC
in_instr  in  INSTR_W  upstream instruction
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_pc  out  PC_W  main entry PC
out_instr  out  INSTR_W  main entry instruction, or NOP_INSTR when out_valid=0

Behaviour:
- Reset (async assert, sync release): main and skid empty; out_valid=0; out_pc=0; out_instr=NOP_INSTR; in_ready=1 on the first cycle after release.
- Handshake definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready & ~freeze.
- in_ready = ~skid_valid & ~freeze & ~flush. This is combinational only through freeze/flush; the skid term is registered.
- Priority at each clock edge is flush > freeze > normal.
- Flush: main and skid both become empty. The input beat in that cycle is discarded (in_ready=0). out_pc retains its last value. out_instr=NOP_INSTR next cycle. Flush while frozen still flushes.
- Freeze (no flush): no state change. out_valid and out_pc/out_instr hold. out_fire=0 regardless of out_ready. in_ready=0.
- Normal, main empty or out_fire:
  - If skid valid: main <= skid; skid <= input if in_fire, else skid becomes empty.
  - Else if in_fire: main <= input.
  - Else: main becomes empty.
- Normal, main full and no out_fire: if in_fire, skid <= input (skid was empty, guaranteed by in_ready).
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput: 1 beat/cycle with out_ready held high.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Simultaneous out_fire and in_fire with skid full: main takes skid, skid takes the input, occupancy stays 2.
- out_valid=0 whenever main is empty. out_instr is muxed to NOP_INSTR; out_pc shows the last registered value.
- rst asserted mid-transfer: immediate return to reset values; held beats are lost.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined: adds ports stall_cnt (out, 32) and flush_cnt (out, 32), both reset to 0 and wrapping modulo 2^32.
  - stall_cnt increments each cycle with (freeze | (out_valid & ~out_ready)) & ~flush.
  - flush_cnt increments each cycle flush=1.
- Undefined: ports and counters absent; datapath behaviour is identical.

Test Plan:
- Reset, then in_valid=1, in_pc=0x100, in_instr=0x12345678, out_ready=1 -> next cycle out_valid=1, out_pc=0x100, out_instr=0x12345678; before that, out_instr=0xE0000000.
- Stream PCs 0x0,0x4,0x8,... with out_ready=1 for 10 cycles -> one output per cycle, in order, with 1-cycle latency.
- out_ready=0 while sending 0x0,0x4,0x8 -> 0x0 in main, 0x4 in skid, in_ready=0 and 0x8 held upstream. Then out_ready=1 -> 0x0, 0x4, 0x8 emitted on consecutive cycles with no loss.
- Main=0x10, skid=0x14, then flush=1 with in_valid=1 (PC 0x18) -> next cycle out_valid=0, out_instr=0xE0000000, in_ready=1; 0x10/0x14/0x18 are never emitted.
- freeze=1 for 3 cycles with out_ready=1 and main=0x20 -> out_pc stays 0x20 and out_valid=1; no out_fire; in_ready=0. After release, 0x20 is emitted once. With PIPE_STAGE_STATS_EN, stall_cnt=3.
- freeze=1 and flush=1 in the same cycle -> stage empties (flush wins); flush_cnt=1.
